// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel edge engine.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sobel kernel weights: outer taps and centre tap of each column/row
  localparam int K_SIDE = 1;
  localparam int K_MID  = 2;

  // Width that holds |Gx|+|Gy| <= 8*(2^dw-1) without overflow
  function automatic int mag_w(input int data_width);
    return data_width + 3;
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / result-out valid/ready bundle for sobel_stream.
interface sobel_stream_if
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_W      = 3,
  parameter int COL_W      = 3
) ();

  logic                             s_valid;
  logic                             s_ready;
  logic [DATA_WIDTH-1:0]            s_data;
  logic                             o_valid;
  logic                             o_ready;
  logic [ROW_W-1:0]                 o_row;
  logic [COL_W-1:0]                 o_col;
  logic [mag_w(DATA_WIDTH)-1:0]     o_data;
  logic                             o_edge;

  modport master (
    output s_valid, s_data, o_ready,
    input  s_ready, o_valid, o_row, o_col, o_data, o_edge
  );

  modport slave (
    input  s_valid, s_data, o_ready,
    output s_ready, o_valid, o_row, o_col, o_data, o_edge
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of storage: combinational read and write of the same
// address in one cycle, so the old word leaves as the new one arrives.
module sobel_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // NOTE: no reset on the row storage -- every word is rewritten before
  // it reaches the window, and a reset would prevent RAM inference.
  // NOTE: non-blocking so the read above still sees the pre-edge word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine: raster pixels in, |Gx|+|Gy| (or an edge bit)
// per interior pixel out, with a single backpressured output register.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int BINARY_MODE = 0,
  parameter int ROW_W       = $clog2(IMG_HEIGHT),
  parameter int COL_W       = $clog2(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH+2:0] thresh,
  output logic                  busy,
  output logic                  done,
  sobel_stream_if.slave         bus
);

  localparam int MW = mag_w(DATA_WIDTH);

  state_e                r_state;
  state_e                w_next;
  logic [ROW_W-1:0]      r_in_row;
  logic [COL_W-1:0]      r_in_col;
  logic [MW-1:0]         r_thresh;

  logic                  r_o_valid;
  logic [ROW_W-1:0]      r_o_row;
  logic [COL_W-1:0]      r_o_col;
  logic [MW-1:0]         r_o_data;
  logic                  r_o_edge;

  logic                  w_s_ready;
  logic                  w_accept;
  logic                  w_row_end;
  logic                  w_last;
  logic                  w_emit;

  logic [DATA_WIDTH-1:0] w_lb0_rd;
  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic [DATA_WIDTH-1:0] w_col [3];
  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic [DATA_WIDTH-1:0] w_p   [3][3];

  logic [MW-1:0]         w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [MW-1:0]         w_gx, w_gy;
  logic [MW-1:0]         w_abs_x, w_abs_y;
  logic [MW-1:0]         w_mag;
  logic                  w_edge;

  // Handshake and frame position

  assign w_s_ready = (r_state == RUN) && (!r_o_valid || bus.o_ready);
  assign w_accept  = bus.s_valid && w_s_ready;
  assign w_row_end = (r_in_col == COL_W'(IMG_WIDTH - 1));
  assign w_last    = w_accept && w_row_end && (r_in_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_emit    = w_accept && (r_in_row >= ROW_W'(2)) && (r_in_col >= COL_W'(2));

  // FSM

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!r_o_valid || bus.o_ready) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_row <= '0;
      r_in_col <= '0;
      r_thresh <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_in_row <= '0;
      r_in_col <= '0;
      r_thresh <= thresh;
    end else if (w_accept) begin
      if (w_row_end) begin
        r_in_col <= '0;
        r_in_row <= w_last ? '0 : r_in_row + ROW_W'(1);
      end else begin
        r_in_col <= r_in_col + COL_W'(1);
      end
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the one above it

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(COL_W)) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_in_col),
    .i_wdata (bus.s_data),
    .o_rdata (w_lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(COL_W)) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_in_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  assign w_col[0] = w_lb1_rd;
  assign w_col[1] = w_lb0_rd;
  assign w_col[2] = bus.s_data;

  // Window is pure datapath; columns 0/1 of each row flush stale contents
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
        r_win[r][2] <= w_col[r];
      end
    end
  end

  // Post-shift view of the window, so a result leaves with its own pixel
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_p[r][0] = r_win[r][1];
      w_p[r][1] = r_win[r][2];
      w_p[r][2] = w_col[r];
    end
  end

  // Arithmetic

  function automatic logic [MW-1:0] tap3(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b,
                                         input logic [DATA_WIDTH-1:0] c);
    return MW'(K_SIDE) * MW'(a) + MW'(K_MID) * MW'(b) + MW'(K_SIDE) * MW'(c);
  endfunction

  assign w_gx_pos = tap3(w_p[0][2], w_p[1][2], w_p[2][2]);
  assign w_gx_neg = tap3(w_p[0][0], w_p[1][0], w_p[2][0]);
  assign w_gy_pos = tap3(w_p[2][0], w_p[2][1], w_p[2][2]);
  assign w_gy_neg = tap3(w_p[0][0], w_p[0][1], w_p[0][2]);

  // Gx/Gy are two's-complement; the MSB is the sign
  assign w_gx    = w_gx_pos - w_gx_neg;
  assign w_gy    = w_gy_pos - w_gy_neg;
  assign w_abs_x = w_gx[MW-1] ? (MW'(0) - w_gx) : w_gx;
  assign w_abs_y = w_gy[MW-1] ? (MW'(0) - w_gy) : w_gy;
  assign w_mag   = w_abs_x + w_abs_y;
  assign w_edge  = (w_mag >= r_thresh);

  // Output register

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      r_o_row   <= '0;
      r_o_col   <= '0;
      r_o_data  <= '0;
      r_o_edge  <= 1'b0;
    end else if (w_emit) begin
      r_o_valid <= 1'b1;
      r_o_row   <= r_in_row - ROW_W'(1);
      r_o_col   <= r_in_col - COL_W'(1);
      r_o_data  <= (BINARY_MODE != 0) ? {{(MW-1){1'b0}}, w_edge} : w_mag;
      r_o_edge  <= w_edge;
    end else if (bus.o_ready) begin
      r_o_valid <= 1'b0;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.o_valid = r_o_valid;
  assign bus.o_row   = r_o_row;
  assign bus.o_col   = r_o_col;
  assign bus.o_data  = r_o_data;
  assign bus.o_edge  = r_o_edge;

endmodule
